// File: rtl/psum_align_ctrl_if.sv
// Bus between the partial-sum alignment controller and its surroundings:
// tile control, downstream handshake and the per-column FIFO bank hooks.
interface psum_align_ctrl_if #(
    parameter int COL   = 8,
    parameter int ROW_W = 8
);
    logic             start;
    logic [ROW_W-1:0] num_rows;
    logic             out_ready;
    logic             fifo_isempty;
    logic             fifo_isfull;
    logic             fifo_en;
    logic [COL-1:0]   fifo_write_en;
    logic             fifo_read_en;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic             overflow_err;

    modport master (
        output start, num_rows, out_ready, fifo_isempty, fifo_isfull,
        input  fifo_en, fifo_write_en, fifo_read_en, out_valid, busy, done, overflow_err
    );

    modport slave (
        input  start, num_rows, out_ready, fifo_isempty, fifo_isfull,
        output fifo_en, fifo_write_en, fifo_read_en, out_valid, busy, done, overflow_err
    );
endinterface

// File: rtl/psum_align_ctrl.sv
// Skewed write / aligned read sequencer for the systolic-array psum FIFO bank.
// Optional: PSUM_CTRL_BACKPRESSURE_EN makes reads honor out_ready. Requires COL >= 2.
module psum_align_ctrl #(
    parameter int COL   = 8,
    parameter int LAT   = 4,
    parameter int ROW_W = 8,
    parameter int DEPTH = COL
) (
    input  logic               clk,
    input  logic               rstn,
    psum_align_ctrl_if.slave   bus
);

    localparam int RR_W = $clog2(DEPTH + 1);
    localparam int LC_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [COL-1:0]  TAIL_ONLY = {1'b1, {(COL-1){1'b0}}};
    localparam logic [RR_W-1:0] RR_MAX    = RR_W'(DEPTH);
    localparam logic [LC_W-1:0] LAT_LAST  = LC_W'((LAT > 1) ? (LAT - 2) : 0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_LAT = 3'd1,
        STREAM   = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state_r;
    logic [ROW_W-1:0] num_rows_r;
    logic [ROW_W-1:0] wr_cnt_r;
    logic [ROW_W-1:0] rd_cnt_r;
    logic [LC_W-1:0]  lat_cnt_r;
    logic [COL-1:0]   skew_r;
    logic [RR_W-1:0]  rows_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             out_valid_r;
    logic             overflow_r;

    logic             ready_s;
    logic             accept_s;
    logic             wr_issue_s;
    logic             rd_en_s;
    logic             row_inc_s;
    logic             stream_end_s;
    logic             drain_end_s;
    logic             overflow_hit_s;
    logic [ROW_W-1:0] rd_cnt_next_s;
    logic             unused_s;

`ifdef PSUM_CTRL_BACKPRESSURE_EN
    assign ready_s  = bus.out_ready;
    assign unused_s = bus.fifo_isempty;
`else
    assign ready_s  = 1'b1;
    assign unused_s = bus.fifo_isempty ^ bus.out_ready;
`endif

    assign accept_s       = (state_r == IDLE) && bus.start;
    assign row_inc_s      = skew_r[COL-1];
    assign rd_en_s        = ready_s && (rows_ready_r != {RR_W{1'b0}}) &&
                            ((state_r == STREAM) || (state_r == DRAIN));
    assign rd_cnt_next_s  = rd_cnt_r + {{(ROW_W-1){1'b0}}, rd_en_s};
    assign stream_end_s   = (wr_cnt_r == num_rows_r) && (skew_r == TAIL_ONLY);
    assign overflow_hit_s = (|skew_r) && bus.fifo_isfull;
    // After an overflow the lost rows never arrive, so an empty bank also ends the drain.
    assign drain_end_s    = (rd_cnt_next_s == num_rows_r) ||
                            (overflow_r && (rows_ready_r == {{(RR_W-1){1'b0}}, rd_en_s}));

    // Decide whether lane 0 writes a row in the next cycle.
    always_comb begin
        wr_issue_s = 1'b0;
        case (state_r)
            IDLE:     wr_issue_s = bus.start && (bus.num_rows != {ROW_W{1'b0}}) && (LAT == 1);
            WAIT_LAT: wr_issue_s = (lat_cnt_r == LAT_LAST);
            STREAM:   wr_issue_s = (wr_cnt_r != num_rows_r);
            default:  wr_issue_s = 1'b0;
        endcase
    end

    // Tile sequencer with registered busy/done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            num_rows_r <= {ROW_W{1'b0}};
            wr_cnt_r   <= {ROW_W{1'b0}};
            lat_cnt_r  <= {LC_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        num_rows_r <= bus.num_rows;
                        lat_cnt_r  <= {LC_W{1'b0}};
                        wr_cnt_r   <= {{(ROW_W-1){1'b0}}, wr_issue_s};
                        busy_r     <= 1'b1;
                        if (bus.num_rows == {ROW_W{1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else if (LAT == 1) begin
                            state_r <= STREAM;
                        end else begin
                            state_r <= WAIT_LAT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                WAIT_LAT: begin
                    if (wr_issue_s) begin
                        state_r  <= STREAM;
                        wr_cnt_r <= {{(ROW_W-1){1'b0}}, 1'b1};
                    end else begin
                        lat_cnt_r <= lat_cnt_r + {{(LC_W-1){1'b0}}, 1'b1};
                    end
                end
                STREAM: begin
                    wr_cnt_r <= wr_cnt_r + {{(ROW_W-1){1'b0}}, wr_issue_s};
                    if (stream_end_s) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= STREAM;
                    end
                end
                DRAIN: begin
                    if (drain_end_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Lane i write enable is lane 0 delayed i cycles, matching the array wavefront.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skew_r <= {COL{1'b0}};
        end else begin
            skew_r <= {skew_r[COL-2:0], wr_issue_s};
        end
    end

    // Count of complete rows sitting in the bank; saturates at DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rows_ready_r <= {RR_W{1'b0}};
        end else if (accept_s) begin
            rows_ready_r <= {RR_W{1'b0}};
        end else if (row_inc_s && !rd_en_s && (rows_ready_r != RR_MAX)) begin
            rows_ready_r <= rows_ready_r + {{(RR_W-1){1'b0}}, 1'b1};
        end else if (!row_inc_s && rd_en_s) begin
            rows_ready_r <= rows_ready_r - {{(RR_W-1){1'b0}}, 1'b1};
        end else begin
            rows_ready_r <= rows_ready_r;
        end
    end

    // Read count, read-data valid and sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt_r    <= {ROW_W{1'b0}};
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            out_valid_r <= rd_en_s;
            if (accept_s) begin
                rd_cnt_r   <= {ROW_W{1'b0}};
                overflow_r <= 1'b0;
            end else begin
                rd_cnt_r   <= rd_cnt_next_s;
                overflow_r <= overflow_r | overflow_hit_s;
            end
        end
    end

    assign bus.fifo_en       = busy_r;
    assign bus.fifo_write_en = skew_r;
    assign bus.fifo_read_en  = rd_en_s;
    assign bus.out_valid     = out_valid_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.overflow_err  = overflow_r;

endmodule

// File: doc/psum_align_ctrl.md
# psum_align_ctrl

Sequencing controller for the per-column partial-sum alignment FIFO bank at the bottom of the systolic array. After a tile `start`, it generates the diagonally skewed per-column write enables that match the array's output wavefront. It tracks how many complete (all-column) rows are buffered and issues a single common read enable, so that aligned rows leave the bank together under downstream backpressure. It also reports tile completion and FIFO overflow.

## Interface
Parameters:
- `COL`, 8, number of array columns / FIFO lanes
- `LAT`, 4, cycles from accepted `start` to the first column-0 psum (≥1)
- `ROW_W`, 8, width of the row-count fields
- `DEPTH`, `COL`, per-lane FIFO depth; sizes `rows_ready`

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `rstn`  in  1  asynchronous, active-low reset
- `start`  in  1  tile start pulse; sampled in IDLE only
- `num_rows`  in  ROW_W  rows in the tile; captured with `start`
- `out_ready`  in  1  downstream can accept an aligned row
- `fifo_isempty`  in  1  all lanes empty (from FIFO bank)
- `fifo_isfull`  in  1  any lane full (from FIFO bank)
- `fifo_en`  out  1  data gate to FIFO bank
- `fifo_write_en`  out  COL  per-lane write enables
- `fifo_read_en`  out  1  common read enable
- `out_valid`  out  1  aligned row on FIFO `out` this cycle
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle tile completion pulse
- `overflow_err`  out  1  sticky overflow flag

## Operation
- States: IDLE, WAIT_LAT, STREAM, DRAIN, DONE.
- IDLE:
  - `start`=1 with `num_rows`≠0 → WAIT_LAT.
  - `start`=1 with `num_rows`=0 → DONE.
  - Either case latches `num_rows`, clears `lat_cnt`, the row counters and `overflow_err`.
- WAIT_LAT: counts LAT cycles → STREAM.
- STREAM:
  - `fifo_write_en[0]` is high for exactly `num_rows` consecutive cycles.
  - `fifo_write_en[i]` equals `fifo_write_en[0]` delayed by i cycles, via a COL-stage shift register.
  - → DRAIN on the cycle after the last `fifo_write_en[COL-1]` pulse.
- DRAIN: waits until `rd_cnt` reaches `num_rows` → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `rows_ready` (0..DEPTH):
  - +1 at each edge ending a cycle with `fifo_write_en[COL-1]`=1.
  - −1 on each `fifo_read_en`.
  - Simultaneous increment and decrement leave it unchanged.
- `fifo_read_en` = `out_ready` & (`rows_ready`≠0) & state∈{STREAM, DRAIN}. This is combinational.
- `rd_cnt` increments on each `fifo_read_en`.
- `fifo_en` = `busy`.
- Writes are never throttled, because the array cannot stall.
- `overflow_err` sets on any cycle with |`fifo_write_en` & `fifo_isfull`, and holds until the next accepted `start` or reset.
- `start` during any non-IDLE state is ignored.
- Reset mid-operation: every output goes to 0, state returns to IDLE, and all counters clear. The FIFO bank shares `rstn`, so the two stay consistent.

## Timing
- Reset values: every output is 0.
- Cycle 0 is the cycle `start` is sampled.
- First `fifo_write_en[0]` is in cycle LAT.
- First `fifo_write_en[COL-1]` is in cycle LAT+COL-1.
- With `out_ready` tied high:
  - First `fifo_read_en` is in cycle LAT+COL.
  - Last `fifo_read_en` is in cycle LAT+COL+N-1.
  - `done` is in cycle LAT+COL+N.
- `out_valid` is `fifo_read_en` delayed one cycle, matching the FIFO's registered read. `done` therefore coincides with the last `out_valid`.
- With `num_rows`=0, `done` is in cycle 1 and no enables are issued.
- Backpressure: a low `out_ready` delays reads one-for-one. Lane 0 overflows once it is DEPTH rows ahead of the reads; this is flagged, not prevented.

## Configuration
- `PSUM_CTRL_BACKPRESSURE_EN` defined: `out_ready` is honored as described above.
- Not defined:
  - `out_ready` is ignored and treated as 1.
  - Reads issue whenever `rows_ready`≠0.
  - `overflow_err` can then only set through a FIFO fault.

## Test plan
- Reset, then idle: all outputs 0; `start` with `num_rows`=0 → `done` in cycle 1, no write or read enables.
- COL=8, LAT=4, N=3, `out_ready`=1:
  - `fifo_write_en[0]` high in cycles 4–6 and `fifo_write_en[7]` in cycles 11–13.
  - `fifo_read_en` high in cycles 12–14.
  - `out_valid` high in cycles 13–15; `done` in cycle 15.
- N=5 with `out_ready` low in cycles 12–14: reads slip 3 cycles, `done` in cycle 20, `overflow_err`=0.
- N=20 with `out_ready` held low: `overflow_err` sets when lane 0 writes while `fifo_isfull`=1, stays set, and clears on the next `start`.
- Assert `rstn` low mid-STREAM: outputs 0 immediately; a new `start` after release runs cleanly. A second `start` sent while busy is ignored.
